// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage instruction fetch controller.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0000;
    localparam logic [31:0] PADDR_MASK_DEF = 32'h1FFF_FFFF;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } fetch_slot_t;

    // Physical address of the 64-bit aligned pair that holds pc.
    function automatic logic [31:0] pair_paddr(input logic [31:0] pc, input logic [31:0] mask);
        return {pc[31:3], 3'b000} & mask;
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Holding register for the fetched pair while the controller presents it.
// Drop clears the contents so the idle outputs read as zero.
module inst_fetch_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drop,
    input  fetch_slot_t load_slot,
    input  logic [31:0] load_inst2,
    input  logic        load_dual,
    output fetch_slot_t slot,
    output logic [31:0] inst2,
    output logic        dual
);

    fetch_slot_t slot_r;
    logic [31:0] inst2_r;
    logic        dual_r;

    // Capture on load, clear on drop or reset, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || drop) begin
            slot_r  <= '0;
            inst2_r <= 32'h0000_0000;
            dual_r  <= 1'b0;
        end else if (load) begin
            slot_r  <= load_slot;
            inst2_r <= load_inst2;
            dual_r  <= load_dual;
        end else begin
            slot_r  <= slot_r;
            inst2_r <= inst2_r;
            dual_r  <= dual_r;
        end
    end

    assign slot  = slot_r;
    assign inst2 = inst2_r;
    assign dual  = dual_r;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch controller: one outstanding 64-bit icache fetch, returns
// one or two instructions to the PC register, and swallows redirected fetches.
module inst_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] PADDR_MASK = PADDR_MASK_DEF,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_curr,
    input  logic        redirect,
    input  logic        stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic        inst_data_ok1,
    output logic        inst_data_ok2,
    output logic [31:0] inst_rdata1,
    output logic [31:0] inst_rdata2,
    output logic [31:0] inst_pc1,
    output logic        inst_adel
);

    fetch_state_t state_r, state_s;
    logic         discard_r, discard_s;
    logic [31:0]  fetch_pc_r, fetch_pc_s;
    logic [31:0]  addr_r, addr_s;
    logic         load_s, drop_s, load_dual_s, ok1_s;
    fetch_slot_t  load_slot_s, buf_slot_s;
    logic [31:0]  load_inst2_s, buf_inst2_s;
    logic         buf_dual_s;

    // State register plus fetch PC, bus address and discard flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            discard_r  <= 1'b0;
            fetch_pc_r <= 32'h0000_0000;
            addr_r     <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            discard_r  <= discard_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
        end
    end

    // Next state, buffer load/drop and redirect bookkeeping.
    always_comb begin
        state_s      = state_r;
        discard_s    = discard_r;
        fetch_pc_s   = fetch_pc_r;
        addr_s       = addr_r;
        load_s       = 1'b0;
        drop_s       = 1'b0;
        load_slot_s  = '0;
        load_inst2_s = 32'h0000_0000;
        load_dual_s  = 1'b0;
        ok1_s        = (state_r == RESP) && !stall && !redirect;
        case (state_r)
            IDLE: begin
                if (!stall && !redirect) begin
                    fetch_pc_s = pc_curr;
                    if (pc_curr[1:0] == 2'b00) begin
                        state_s = REQ;
                        addr_s  = pair_paddr(pc_curr, PADDR_MASK);
                    end else begin
                        // Misaligned PC never reaches the bus.
                        state_s     = RESP;
                        load_s      = 1'b1;
                        load_slot_s = '{inst: NOP_INST, pc: pc_curr, adel: 1'b1};
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    discard_s = 1'b1;
                end else begin
                    discard_s = discard_r;
                end
                if (inst_addr_ok) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    discard_s = 1'b0;
                    if (discard_r || redirect) begin
                        state_s = IDLE;
                    end else begin
                        state_s      = RESP;
                        load_s       = 1'b1;
                        load_slot_s  = '{inst: (fetch_pc_r[2] ? inst_rdata[63:32] : inst_rdata[31:0]),
                                         pc: fetch_pc_r, adel: 1'b0};
                        load_inst2_s = inst_rdata[63:32];
                        load_dual_s  = !fetch_pc_r[2];
                    end
                end else if (redirect) begin
                    discard_s = 1'b1;
                end else begin
                    discard_s = discard_r;
                end
            end
            RESP: begin
                if (redirect || !stall) begin
                    state_s = IDLE;
                    drop_s  = 1'b1;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    inst_fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .drop       (drop_s),
        .load_slot  (load_slot_s),
        .load_inst2 (load_inst2_s),
        .load_dual  (load_dual_s),
        .slot       (buf_slot_s),
        .inst2      (buf_inst2_s),
        .dual       (buf_dual_s)
    );

    assign inst_req      = (state_r == REQ);
    assign inst_addr     = addr_r;
    assign inst_data_ok1 = ok1_s;
    assign inst_data_ok2 = ok1_s & buf_dual_s;
    assign inst_rdata1   = buf_slot_s.inst;
    assign inst_rdata2   = buf_inst2_s;
    assign inst_pc1      = buf_slot_s.pc;
    assign inst_adel     = ok1_s & buf_slot_s.adel;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: transaction-level reference model checked
// every cycle, plus literal expectations at the key cycles of each scenario.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, redirect, stall, inst_addr_ok, inst_data_ok;
    logic [31:0] pc_curr;
    logic [63:0] inst_rdata;
    logic        inst_req, inst_data_ok1, inst_data_ok2, inst_adel;
    logic [31:0] inst_addr, inst_rdata1, inst_rdata2, inst_pc1;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pc_curr       (pc_curr),
        .redirect      (redirect),
        .stall         (stall),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .inst_data_ok1 (inst_data_ok1),
        .inst_data_ok2 (inst_data_ok2),
        .inst_rdata1   (inst_rdata1),
        .inst_rdata2   (inst_rdata2),
        .inst_pc1      (inst_pc1),
        .inst_adel     (inst_adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] pc;
        bit          dual;
        bit          adel;
    } resp_t;

    resp_t       exp_q[$];
    bit          mdl_on = 1'b0;
    bit          tx_asked, tx_accepted, tx_live;
    logic [31:0] tx_pc;
    bit          have, e_ok1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic resp_t pair_resp(input logic [31:0] pc, input logic [63:0] data);
        resp_t r;
        int    word;
        word   = (pc / 4) % 2;
        r.i1   = 32'(data >> (32 * word));
        r.i2   = data[63:32];
        r.pc   = pc;
        r.dual = (word == 0);
        r.adel = 1'b0;
        return r;
    endfunction

    // Reference model: at most one fetch token on the bus, and responses queued for the decode buffer.
    always @(posedge clk) begin
        if (rst) begin
            mdl_on      = 1'b1;
            tx_asked    = 1'b0;
            tx_accepted = 1'b0;
            tx_live     = 1'b0;
            exp_q.delete();
        end else if (mdl_on) begin
            if (exp_q.size() != 0) begin
                if (redirect || !stall) exp_q.delete();
            end else if (tx_accepted) begin
                if (inst_data_ok) begin
                    tx_accepted = 1'b0;
                    if (tx_live && !redirect) exp_q.push_back(pair_resp(tx_pc, inst_rdata));
                end else if (redirect) begin
                    tx_live = 1'b0;
                end
            end else if (tx_asked) begin
                if (redirect) tx_live = 1'b0;
                if (inst_addr_ok) begin
                    tx_asked    = 1'b0;
                    tx_accepted = 1'b1;
                end
            end else if (!stall && !redirect) begin
                if (pc_curr % 4 != 0) begin
                    exp_q.push_back('{i1: 32'h0000_0000, i2: 32'h0000_0000, pc: pc_curr, dual: 1'b0, adel: 1'b1});
                end else begin
                    tx_asked = 1'b1;
                    tx_live  = 1'b1;
                    tx_pc    = pc_curr;
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (mdl_on) begin
            have  = (exp_q.size() != 0);
            e_ok1 = have && !stall && !redirect;
            chk("req", 32'(inst_req), 32'(tx_asked));
            if (tx_asked) chk("addr", inst_addr, (tx_pc - (tx_pc % 8)) & 32'h1FFF_FFFF);
            chk("ok1", 32'(inst_data_ok1), 32'(e_ok1));
            chk("ok2", 32'(inst_data_ok2), 32'(e_ok1 && have && exp_q[0].dual));
            chk("adel", 32'(inst_adel), 32'(e_ok1 && have && exp_q[0].adel));
            if (have) begin
                chk("rdata1", inst_rdata1, exp_q[0].i1);
                chk("pc1", inst_pc1, exp_q[0].pc);
                if (exp_q[0].dual) chk("rdata2", inst_rdata2, exp_q[0].i2);
            end
        end
    end

    task automatic cyc(input logic r, input logic [31:0] pc, input logic st, input logic rd,
                       input logic aok, input logic dok, input logic [63:0] rdata);
        @(posedge clk);
        #1;
        rst = r; pc_curr = pc; stall = st; redirect = rd;
        inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rdata;
        #2;
    endtask

    initial begin
        rst = 1'b1; pc_curr = 32'h0; stall = 1'b0; redirect = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 64'h0;

        // Reset
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rst_req", 32'(inst_req), 32'h0);
        chk("rst_addr", inst_addr, 32'h0);
        chk("rst_ok1", 32'(inst_data_ok1), 32'h0);
        chk("rst_rdata1", inst_rdata1, 32'h0);

        // Aligned dual fetch
        cyc(1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("dual_noreq", 32'(inst_req), 32'h0);
        cyc(1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        chk("dual_req", 32'(inst_req), 32'h1);
        chk("dual_addr", inst_addr, 32'h1FC0_0000);
        cyc(1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11111111_22222222);
        chk("dual_early", 32'(inst_data_ok1), 32'h0);
        cyc(1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("dual_ok1", 32'(inst_data_ok1), 32'h1);
        chk("dual_ok2", 32'(inst_data_ok2), 32'h1);
        chk("dual_r1", inst_rdata1, 32'h2222_2222);
        chk("dual_r2", inst_rdata2, 32'h1111_1111);
        chk("dual_pc", inst_pc1, 32'hBFC0_0000);

        // Odd word
        cyc(1'b0, 32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0004, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        chk("odd_addr", inst_addr, 32'h1FC0_0000);
        cyc(1'b0, 32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 1'b1, 64'hAAAA5555_33334444);
        cyc(1'b0, 32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("odd_ok1", 32'(inst_data_ok1), 32'h1);
        chk("odd_ok2", 32'(inst_data_ok2), 32'h0);
        chk("odd_r1", inst_rdata1, 32'hAAAA_5555);
        chk("odd_pc", inst_pc1, 32'hBFC0_0004);

        // Redirect while waiting for data
        cyc(1'b0, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0010, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0100, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0100, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0100, 1'b0, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D);
        cyc(1'b0, 32'hBFC0_0100, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rw_swallow", 32'(inst_data_ok1), 32'h0);
        cyc(1'b0, 32'hBFC0_0100, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        chk("rw_newaddr", inst_addr, 32'h1FC0_0100);
        cyc(1'b0, 32'hBFC0_0100, 1'b0, 1'b0, 1'b0, 1'b1, 64'h01234567_89ABCDEF);
        cyc(1'b0, 32'hBFC0_0100, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rw_r1", inst_rdata1, 32'h89AB_CDEF);
        chk("rw_r2", inst_rdata2, 32'h0123_4567);

        // Redirect in REQ, addr_ok three cycles later
        cyc(1'b0, 32'hBFC0_0200, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0300, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("rq_req0", 32'(inst_req), 32'h1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 32'hBFC0_0300, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
            chk("rq_hold", inst_addr, 32'h1FC0_0200);
        end
        cyc(1'b0, 32'hBFC0_0300, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        chk("rq_req3", 32'(inst_req), 32'h1);
        cyc(1'b0, 32'hBFC0_0300, 1'b0, 1'b0, 1'b0, 1'b1, 64'h99999999_AAAAAAAA);
        cyc(1'b0, 32'hBFC0_0300, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rq_drop", 32'(inst_data_ok1), 32'h0);
        cyc(1'b0, 32'hBFC0_0300, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        chk("rq_newaddr", inst_addr, 32'h1FC0_0300);
        cyc(1'b0, 32'hBFC0_0300, 1'b0, 1'b0, 1'b0, 1'b1, 64'h55555555_66666666);
        cyc(1'b0, 32'hBFC0_0300, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rq_r1", inst_rdata1, 32'h6666_6666);

        // Stall four cycles in RESP
        cyc(1'b0, 32'hBFC0_0400, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0400, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0400, 1'b0, 1'b0, 1'b0, 1'b1, 64'h77777777_88888888);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'hBFC0_0400, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
            chk("st_nook", 32'(inst_data_ok1), 32'h0);
            chk("st_hold", inst_rdata1, 32'h8888_8888);
        end
        cyc(1'b0, 32'hBFC0_0400, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("st_ok1", 32'(inst_data_ok1), 32'h1);
        chk("st_ok2", 32'(inst_data_ok2), 32'h1);

        // Redirect while presenting drops the pair
        cyc(1'b0, 32'hBFC0_0600, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0600, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0600, 1'b0, 1'b0, 1'b0, 1'b1, 64'h12345678_9ABCDEF0);
        cyc(1'b0, 32'hBFC0_0700, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("rr_nook", 32'(inst_data_ok1), 32'h0);
        cyc(1'b0, 32'hBFC0_0700, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rr_gone", inst_rdata1, 32'h0);

        // Misaligned PC
        cyc(1'b0, 32'hBFC0_0002, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("mis_noreq0", 32'(inst_req), 32'h0);
        cyc(1'b0, 32'hBFC0_0002, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("mis_noreq1", 32'(inst_req), 32'h0);
        chk("mis_ok1", 32'(inst_data_ok1), 32'h1);
        chk("mis_adel", 32'(inst_adel), 32'h1);
        chk("mis_r1", inst_rdata1, 32'h0);
        chk("mis_ok2", 32'(inst_data_ok2), 32'h0);
        cyc(1'b0, 32'hBFC0_0008, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);

        // Mid-operation reset; late data_ok is ignored
        cyc(1'b0, 32'hBFC0_0500, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0500, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        cyc(1'b1, 32'hBFC0_0500, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'hBFC0_0500, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFF_EEEEEEEE);
        cyc(1'b0, 32'hBFC0_0500, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("mr_nook", 32'(inst_data_ok1), 32'h0);
        chk("mr_noreq", 32'(inst_req), 32'h0);
        cyc(1'b0, 32'hBFC0_0500, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
